alu_unit: RTL and testbench
===========================

# alu_unit

Sequential 8-bit ALU stage that sits directly upstream of the accumulator register and drives its `ACC_BUS` input. It captures a B operand from `CPU_BUS` and takes the A operand from the accumulator's stored value. On `START` it runs one of eight operations; the multiply is iterative over several cycles, the rest complete in one cycle. It holds the result on `ACC_BUS`, with status flags, until the controller pulses the accumulator's load enable during `DONE`.

## Interface
- `WIDTH`, 8, datapath width; only 8 is supported.

- `CLK` in 1: single clock, rising edge.
- `RST` in 1: reset; synchronous, active-high.
- `CPU_BUS` in 8: B operand source.
- `IB` in 1: load B register from `CPU_BUS` at the edge.
- `ACC_Q` in 8: current accumulator contents (A operand).
- `OP` in 3: operation code (see Operation).
- `START` in 1: begin operation; sampled only in IDLE.
- `BUSY` out 1: multiply in progress.
- `DONE` out 1: one-cycle pulse; `ACC_BUS` and `FLAGS` are valid.
- `ACC_BUS` out 8: result, held until the next completion or reset.
- `FLAGS` out 4: {Z, C, N, V}.
- `MUL_HI` out 8: high byte of the last product.

## Operation
- **Reset values:** `ACC_BUS`=0, `FLAGS`=0, `MUL_HI`=0, B=0, `BUSY`=0, `DONE`=0, state=IDLE.
- **B register:** `IB` writes B at any time, in any state.
- **Operand capture:** operands are latched at the `START` edge. Later `IB` writes do not disturb an in-flight operation.
- **OP encoding:**
  - 000 ADD: A+B
  - 001 SUB: A−B
  - 010 AND
  - 011 OR
  - 100 XOR
  - 101 SHL: A<<1, LSB 0
  - 110 SHR: A>>1 logical, MSB 0
  - 111 MUL: A×B unsigned, 16-bit; low byte to `ACC_BUS`, high byte to `MUL_HI`
- **State machine:**
  - IDLE: `START`=1 with OP≠MUL → FIN, writing result and flags at that edge.
  - IDLE: `START`=1 with OP=MUL → MUL, clearing the product and setting the counter to 0.
  - MUL: one shift-add step per cycle; counter 0..7; after the 8th step → FIN, writing result and flags.
  - FIN: `DONE`=1 for exactly one cycle, then → IDLE.
- **`START` handling:** ignored in MUL and FIN. There is no queuing.
- **Flags:** updated only at the completion edge; otherwise held.
  - Z = (`ACC_BUS`==0).
  - N = bit 7 of `ACC_BUS`.
  - C:
    - ADD: carry out.
    - SUB: borrow, i.e. 1 when A<B unsigned.
    - SHL: old A[7].
    - SHR: old A[0].
    - MUL: (`MUL_HI`≠0).
    - Logic ops: 0.
  - V:
    - ADD/SUB: signed overflow.
    - All other ops: 0.
- **Widths:** ADD/SUB are computed 9 bits wide; bit 8 feeds C. All results are truncated to 8 bits.
- **`MUL_HI`:** changes only on MUL completion.
- **Reset mid-operation:** aborts a MUL, discards the partial product, and produces no `DONE`.

## Timing
- **Single-cycle ops:** `START` sampled at edge k; `ACC_BUS`/`FLAGS` valid and `DONE`=1 in cycle k+1. Latency is 1.
- **MUL:**
  - `START` sampled at edge k.
  - `BUSY`=1 in cycles k+1..k+8.
  - `DONE`=1 in cycle k+9. Latency is 9.
- **Back-to-back:** the earliest next accepted `START` is sampled at the edge ending the `DONE` cycle, when state is already IDLE. A `START` held high across the `DONE` cycle is therefore accepted once per IDLE cycle.
- **Controller contract:** assert the accumulator's load enable during `DONE`. `ACC_BUS` stays stable afterwards, so a later load is also legal.
- **Same-edge writes:** `IB` and `START` asserted at the same edge use the old B; the new B applies to the next operation.

## Configuration
- **`ALU_MUL_EN` defined:** MUL behaves as above.
- **`ALU_MUL_EN` undefined:**
  - No multiplier logic is built and the MUL state does not exist.
  - OP=111 completes in 1 cycle with `ACC_BUS`=A, Z/N computed from A, C=V=0.
  - `MUL_HI` is tied to 0 and `BUSY` is tied to 0.

## Structure
- **Shared package `alu_pkg`:**
  - OP code constants
  - state enum (IDLE, MUL, FIN)
  - flag bit indices (Z=3, C=2, N=1, V=0)
  - `WIDTH` constant
- **Sub-module `alu_mul_seq`:** shift-add multiplier with 8-bit multiplicand, 16-bit product register and 3-bit counter, plus step/clear inputs. It is instantiated only under `ALU_MUL_EN`.
- Everything else (operand latches, combinational op mux, FSM, flag logic) lives in `alu_unit`.

## Test plan
- A=0x7F, B=0x01 (via `IB`), ADD → next cycle `ACC_BUS`=0x80, `FLAGS` Z0 C0 N1 V1, `DONE` 1 cycle.
- A=0x05, B=0x07, SUB → `ACC_BUS`=0xFE, C=1, N=1, V=0; then A=0xFF, ADD B=0x01 → `ACC_BUS`=0x00, Z=1, C=1.
- A=0x81, SHR → `ACC_BUS`=0x40, C=1; SHL → `ACC_BUS`=0x02, C=1.
- MUL (macro on), A=0xFF, B=0xFF → `BUSY` 8 cycles, `DONE` at cycle 9, `ACC_BUS`=0x01, `MUL_HI`=0xFE, C=1. `START` pulses and `IB`=0x00 writes during `BUSY` have no effect on the result.
- `RST` asserted at MUL cycle 4 → next cycle all outputs 0, state IDLE, no `DONE`. A following ADD works normally.
- Macro off, OP=111 with A=0x00 → `DONE` after 1 cycle, `ACC_BUS`=0x00, Z=1, `MUL_HI`=0, `BUSY` never asserted.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the alu_unit slice.
//   - WIDTH datapath constant (only 8 is supported)
//   - OP code constants
//   - FSM state enum
//   - FLAGS bit indices: {Z, C, N, V}
//   - make_flags helper, which packs the four flag bits in that order
package alu_pkg;

   localparam int unsigned WIDTH = 8;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_SHL = 3'b101;
   localparam logic [2:0] OP_SHR = 3'b110;
   localparam logic [2:0] OP_MUL = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_FIN  = 2'd2
   } alu_state_e;

   localparam int unsigned FLAG_Z = 3;
   localparam int unsigned FLAG_C = 2;
   localparam int unsigned FLAG_N = 1;
   localparam int unsigned FLAG_V = 0;

   // Z and N always come from the 8-bit result; C and V depend on the op.
   function automatic logic [3:0] make_flags(input logic [WIDTH-1:0] res,
                                             input logic c,
                                             input logic v);
      logic [3:0] f;
      f         = '0;
      f[FLAG_Z] = (res == '0);
      f[FLAG_C] = c;
      f[FLAG_N] = res[WIDTH-1];
      f[FLAG_V] = v;
      return f;
   endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: iterative shift-add unsigned multiplier, one partial product per step.
// It is instantiated by alu_unit only when ALU_MUL_EN is defined.
//   clk_i        in   clock
//   rst_i        in   synchronous active-high reset
//   clear_i      in   zero the product and the step counter
//   step_i       in   accumulate the partial product for multiplier bit cnt
//   mcand_i      in   multiplicand (held stable by the caller)
//   mplier_i     in   multiplier (held stable by the caller)
//   last_o       out  the current step is the final (8th) one
//   prod_nxt_o   out  product value after the current step
module alu_mul_seq
   import alu_pkg::*;
(
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 clear_i,
   input  logic                 step_i,
   input  logic [WIDTH-1:0]     mcand_i,
   input  logic [WIDTH-1:0]     mplier_i,
   output logic                 last_o,
   output logic [2*WIDTH-1:0]   prod_nxt_o
);

   logic [2*WIDTH-1:0] prod_q, prod_d, addend;
   logic [2:0]         cnt_q, cnt_d;

   always_comb begin
      addend = mplier_i[cnt_q] ? ({{WIDTH{1'b0}}, mcand_i} << cnt_q) : '0;
      prod_nxt_o = prod_q + addend;
      last_o     = (cnt_q == 3'd7);
      prod_d     = prod_q;
      cnt_d      = cnt_q;
      if (clear_i) begin
         prod_d = '0;
         cnt_d  = '0;
      end else if (step_i) begin
         prod_d = prod_nxt_o;
         cnt_d  = cnt_q + 3'd1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         prod_q <= '0;
         cnt_q  <= '0;
      end else begin
         prod_q <= prod_d;
         cnt_q  <= cnt_d;
      end
   end

endmodule

// File: rtl/alu_unit.sv
// alu_unit: sequential 8-bit ALU stage feeding the accumulator's ACC_BUS input.
// The A operand is the accumulator's stored value; B is loaded from CPU_BUS.
// Optional feature macro: ALU_MUL_EN builds the iterative multiplier.
// Without the macro, OP=MUL passes A through in one cycle, and MUL_HI and BUSY read 0.
//   clk_i       in   clock, rising edge
//   rst_i       in   synchronous active-high reset
//   cpu_bus_i   in   B operand source
//   ib_i        in   load B from cpu_bus_i
//   acc_q_i     in   accumulator contents (A operand)
//   op_i        in   operation code
//   start_i     in   begin operation (sampled only in IDLE)
//   busy_o      out  multiply in progress
//   done_o      out  one-cycle completion pulse
//   acc_bus_o   out  result, held until the next completion
//   flags_o     out  {Z, C, N, V}
//   mul_hi_o    out  high byte of the last product
//
// state   | meaning
// IDLE    | waiting for START
// MUL     | one shift-add step per cycle (ALU_MUL_EN only)
// FIN     | DONE pulse; result and flags valid
module alu_unit
   import alu_pkg::*;
(
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [WIDTH-1:0] cpu_bus_i,
   input  logic             ib_i,
   input  logic [WIDTH-1:0] acc_q_i,
   input  logic [2:0]       op_i,
   input  logic             start_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] acc_bus_o,
   output logic [3:0]       flags_o,
   output logic [WIDTH-1:0] mul_hi_o
);

   alu_state_e       state_q, state_d;
   logic [WIDTH-1:0] acc_bus_q, acc_bus_d;
   logic [3:0]       flags_q, flags_d;
   logic [WIDTH-1:0] b_q, b_d;

   logic [WIDTH:0]   sum9, diff9;
   logic [WIDTH-1:0] op_res;
   logic             op_c, op_v;

`ifdef ALU_MUL_EN
   logic [WIDTH-1:0]   mul_hi_q, mul_hi_d;
   logic [WIDTH-1:0]   mul_a_q, mul_a_d, mul_b_q, mul_b_d;
   logic               mul_clear, mul_step, mul_last;
   logic [2*WIDTH-1:0] mul_prod_nxt;

   alu_mul_seq u_mul (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .clear_i    (mul_clear),
      .step_i     (mul_step),
      .mcand_i    (mul_a_q),
      .mplier_i   (mul_b_q),
      .last_o     (mul_last),
      .prod_nxt_o (mul_prod_nxt)
   );
`endif

   // Single-cycle result; uses the B already in the register, so an IB at the
   // same edge as START only affects the following operation.
   always_comb begin
      sum9   = {1'b0, acc_q_i} + {1'b0, b_q};
      diff9  = {1'b0, acc_q_i} - {1'b0, b_q};
      op_res = acc_q_i;
      op_c   = 1'b0;
      op_v   = 1'b0;
      case (op_i)
         OP_ADD: begin
            op_res = sum9[WIDTH-1:0];
            op_c   = sum9[WIDTH];
            op_v   = (acc_q_i[WIDTH-1] == b_q[WIDTH-1]) &&
                     (sum9[WIDTH-1] != acc_q_i[WIDTH-1]);
         end
         OP_SUB: begin
            op_res = diff9[WIDTH-1:0];
            op_c   = diff9[WIDTH];
            op_v   = (acc_q_i[WIDTH-1] != b_q[WIDTH-1]) &&
                     (diff9[WIDTH-1] != acc_q_i[WIDTH-1]);
         end
         OP_AND: op_res = acc_q_i & b_q;
         OP_OR:  op_res = acc_q_i | b_q;
         OP_XOR: op_res = acc_q_i ^ b_q;
         OP_SHL: begin
            op_res = {acc_q_i[WIDTH-2:0], 1'b0};
            op_c   = acc_q_i[WIDTH-1];
         end
         OP_SHR: begin
            op_res = {1'b0, acc_q_i[WIDTH-1:1]};
            op_c   = acc_q_i[0];
         end
         OP_MUL: op_res = acc_q_i;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      acc_bus_d = acc_bus_q;
      flags_d   = flags_q;
      b_d       = ib_i ? cpu_bus_i : b_q;
`ifdef ALU_MUL_EN
      mul_hi_d  = mul_hi_q;
      mul_a_d   = mul_a_q;
      mul_b_d   = mul_b_q;
      mul_clear = 1'b0;
      mul_step  = 1'b0;
`endif
      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
`ifdef ALU_MUL_EN
               if (op_i == OP_MUL) begin
                  state_d   = ST_MUL;
                  mul_clear = 1'b1;
                  mul_a_d   = acc_q_i;
                  mul_b_d   = b_q;
               end else
`endif
               begin
                  state_d   = ST_FIN;
                  acc_bus_d = op_res;
                  flags_d   = make_flags(op_res, op_c, op_v);
               end
            end
         end
`ifdef ALU_MUL_EN
         ST_MUL: begin
            mul_step = 1'b1;
            if (mul_last) begin
               state_d   = ST_FIN;
               acc_bus_d = mul_prod_nxt[WIDTH-1:0];
               mul_hi_d  = mul_prod_nxt[2*WIDTH-1:WIDTH];
               flags_d   = make_flags(mul_prod_nxt[WIDTH-1:0],
                                      (mul_prod_nxt[2*WIDTH-1:WIDTH] != '0), 1'b0);
            end
         end
`endif
         ST_FIN:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= ST_IDLE;
         acc_bus_q <= '0;
         flags_q   <= '0;
         b_q       <= '0;
`ifdef ALU_MUL_EN
         mul_hi_q  <= '0;
         mul_a_q   <= '0;
         mul_b_q   <= '0;
`endif
      end else begin
         state_q   <= state_d;
         acc_bus_q <= acc_bus_d;
         flags_q   <= flags_d;
         b_q       <= b_d;
`ifdef ALU_MUL_EN
         mul_hi_q  <= mul_hi_d;
         mul_a_q   <= mul_a_d;
         mul_b_q   <= mul_b_d;
`endif
      end
   end

   assign done_o    = (state_q == ST_FIN);
   assign acc_bus_o = acc_bus_q;
   assign flags_o   = flags_q;
`ifdef ALU_MUL_EN
   assign busy_o    = (state_q == ST_MUL);
   assign mul_hi_o  = mul_hi_q;
`else
   assign busy_o    = 1'b0;
   assign mul_hi_o  = '0;
`endif

endmodule

// File: tb/tb_alu_unit.sv
// tb_alu_unit: directed self-checking bench for alu_unit.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// ALU_MUL_EN selects between the multiplier scenarios and the pass-through scenario.
module tb_alu_unit;

   logic       clk = 1'b0;
   logic       rst, ib, start;
   logic [7:0] cpu_bus, acc_q;
   logic [2:0] op;
   logic       busy, done;
   logic [7:0] acc_bus, mul_hi;
   logic [3:0] flags;

   int n_checks = 0;
   int n_fail   = 0;

   localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, AND_ = 3'b010, OR_ = 3'b011,
                          XOR_ = 3'b100, SHL = 3'b101, SHR = 3'b110, MUL = 3'b111;

   alu_unit dut (
      .clk_i     (clk),
      .rst_i     (rst),
      .cpu_bus_i (cpu_bus),
      .ib_i      (ib),
      .acc_q_i   (acc_q),
      .op_i      (op),
      .start_i   (start),
      .busy_o    (busy),
      .done_o    (done),
      .acc_bus_o (acc_bus),
      .flags_o   (flags),
      .mul_hi_o  (mul_hi)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic load_b(input logic [7:0] b);
      @(negedge clk);
      cpu_bus = b; ib = 1'b1; start = 1'b0;
      @(negedge clk);
      ib = 1'b0;
   endtask

   // Drives one START in a fresh cycle and returns in the cycle after it.
   task automatic issue_op(input logic [7:0] a, input logic [2:0] o);
      @(negedge clk);
      acc_q = a; op = o; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1; ib = 1'b0; start = 1'b0; cpu_bus = 8'h00; acc_q = 8'h00; op = ADD;
      repeat (2) @(negedge clk);
      n_checks++; if (acc_bus !== 8'h00) begin n_fail++; $display("FAIL reset_acc: got %h want 00", acc_bus); end
      n_checks++; if (flags !== 4'h0) begin n_fail++; $display("FAIL reset_flags: got %b want 0000", flags); end
      n_checks++; if (mul_hi !== 8'h00) begin n_fail++; $display("FAIL reset_mul_hi: got %h want 00", mul_hi); end
      n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL reset_busy_done: got %b%b want 00", busy, done); end
      rst = 1'b0;
      // B cleared by reset: 0 | B == 0
      issue_op(8'h00, OR_);
      n_checks++; if (acc_bus !== 8'h00 || flags !== 4'b1000) begin n_fail++; $display("FAIL reset_b: got %h/%b want 00/1000", acc_bus, flags); end
   endtask

   task automatic test_add;
      load_b(8'h01);
      issue_op(8'h7F, ADD);
      n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL add_done: got %b want 1", done); end
      n_checks++; if (acc_bus !== 8'h80) begin n_fail++; $display("FAIL add_res: got %h want 80", acc_bus); end
      n_checks++; if (flags !== 4'b0011) begin n_fail++; $display("FAIL add_flags: got %b want 0011", flags); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL add_busy: got %b want 0", busy); end
      @(negedge clk);
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL add_done_pulse: got %b want 0", done); end
      n_checks++; if (acc_bus !== 8'h80 || flags !== 4'b0011) begin n_fail++; $display("FAIL add_hold: got %h/%b want 80/0011", acc_bus, flags); end
   endtask

   task automatic test_sub;
      load_b(8'h07);
      issue_op(8'h05, SUB);
      n_checks++; if (acc_bus !== 8'hFE || flags !== 4'b0110) begin n_fail++; $display("FAIL sub_borrow: got %h/%b want FE/0110", acc_bus, flags); end
      load_b(8'h01);
      issue_op(8'hFF, ADD);
      n_checks++; if (acc_bus !== 8'h00 || flags !== 4'b1100) begin n_fail++; $display("FAIL add_wrap: got %h/%b want 00/1100", acc_bus, flags); end
      issue_op(8'h80, SUB);
      n_checks++; if (acc_bus !== 8'h7F || flags !== 4'b0001) begin n_fail++; $display("FAIL sub_ovf: got %h/%b want 7F/0001", acc_bus, flags); end
      issue_op(8'h01, SUB);
      n_checks++; if (acc_bus !== 8'h00 || flags !== 4'b1000) begin n_fail++; $display("FAIL sub_equal: got %h/%b want 00/1000", acc_bus, flags); end
   endtask

   task automatic test_shift;
      issue_op(8'h81, SHR);
      n_checks++; if (acc_bus !== 8'h40 || flags !== 4'b0100) begin n_fail++; $display("FAIL shr: got %h/%b want 40/0100", acc_bus, flags); end
      issue_op(8'h81, SHL);
      n_checks++; if (acc_bus !== 8'h02 || flags !== 4'b0100) begin n_fail++; $display("FAIL shl: got %h/%b want 02/0100", acc_bus, flags); end
      issue_op(8'h40, SHL);
      n_checks++; if (acc_bus !== 8'h80 || flags !== 4'b0010) begin n_fail++; $display("FAIL shl_n: got %h/%b want 80/0010", acc_bus, flags); end
   endtask

   task automatic test_logic;
      load_b(8'h3C);
      issue_op(8'hF0, AND_);
      n_checks++; if (acc_bus !== 8'h30 || flags !== 4'b0000) begin n_fail++; $display("FAIL and: got %h/%b want 30/0000", acc_bus, flags); end
      issue_op(8'hF0, OR_);
      n_checks++; if (acc_bus !== 8'hFC || flags !== 4'b0010) begin n_fail++; $display("FAIL or: got %h/%b want FC/0010", acc_bus, flags); end
      issue_op(8'hF0, XOR_);
      n_checks++; if (acc_bus !== 8'hCC || flags !== 4'b0010) begin n_fail++; $display("FAIL xor: got %h/%b want CC/0010", acc_bus, flags); end
   endtask

   task automatic test_same_edge;
      // B is 3C here; the IB at the START edge must not affect this ADD
      @(negedge clk);
      cpu_bus = 8'h01; ib = 1'b1; acc_q = 8'h10; op = ADD; start = 1'b1;
      @(negedge clk);
      ib = 1'b0; start = 1'b0;
      n_checks++; if (acc_bus !== 8'h4C) begin n_fail++; $display("FAIL same_edge_old_b: got %h want 4C", acc_bus); end
      issue_op(8'h10, ADD);
      n_checks++; if (acc_bus !== 8'h11) begin n_fail++; $display("FAIL same_edge_new_b: got %h want 11", acc_bus); end
   endtask

   task automatic test_back_to_back;
      logic [3:0] seen;
      @(negedge clk);
      acc_q = 8'h01; op = ADD; start = 1'b1;
      seen = '0;
      for (int i = 3; i >= 0; i--) begin
         @(negedge clk);
         seen[i] = done;
      end
      start = 1'b0;
      n_checks++; if (seen !== 4'b1010) begin n_fail++; $display("FAIL b2b_done_seq: got %b want 1010", seen); end
      n_checks++; if (acc_bus !== 8'h02 || busy !== 1'b0) begin n_fail++; $display("FAIL b2b_res: got %h busy %b want 02 busy 0", acc_bus, busy); end
   endtask

`ifdef ALU_MUL_EN
   task automatic test_mul;
      logic busy_ok, done_early;
      load_b(8'h0B);
      issue_op(8'h0D, MUL);
      busy_ok = 1'b1; done_early = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         if (busy !== 1'b1) busy_ok = 1'b0;
         if (done !== 1'b0) done_early = 1'b1;
         @(negedge clk);
      end
      n_checks++; if (!busy_ok || done_early) begin n_fail++; $display("FAIL mul_small_busy: busy_ok %b done_early %b want 1 0", busy_ok, done_early); end
      n_checks++; if (done !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL mul_small_done: done %b busy %b want 1 0", done, busy); end
      n_checks++; if (acc_bus !== 8'h8F || mul_hi !== 8'h00 || flags !== 4'b0010) begin n_fail++; $display("FAIL mul_small: got %h %h/%b want 8F 00/0010", acc_bus, mul_hi, flags); end

      load_b(8'hFF);
      issue_op(8'hFF, MUL);
      busy_ok = 1'b1; done_early = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         if (busy !== 1'b1) busy_ok = 1'b0;
         if (done !== 1'b0) done_early = 1'b1;
         // disturbances that must not affect the in-flight multiply
         start = i[0]; op = ADD; acc_q = 8'h00; cpu_bus = 8'h00; ib = i[0];
         @(negedge clk);
      end
      start = 1'b0; ib = 1'b0;
      n_checks++; if (!busy_ok || done_early) begin n_fail++; $display("FAIL mul_ff_busy: busy_ok %b done_early %b want 1 0", busy_ok, done_early); end
      n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL mul_ff_done: got %b want 1", done); end
      n_checks++; if (acc_bus !== 8'h01 || mul_hi !== 8'hFE || flags !== 4'b0100) begin n_fail++; $display("FAIL mul_ff: got %h %h/%b want 01 FE/0100", acc_bus, mul_hi, flags); end

      // B is now 00; MUL_HI must survive a non-multiply op
      issue_op(8'h05, ADD);
      n_checks++; if (acc_bus !== 8'h05 || mul_hi !== 8'hFE) begin n_fail++; $display("FAIL mul_hi_hold: got %h %h want 05 FE", acc_bus, mul_hi); end
   endtask

   task automatic test_mul_reset;
      logic saw_done;
      load_b(8'h02);
      issue_op(8'h03, MUL);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_checks++; if (acc_bus !== 8'h00 || flags !== 4'h0 || mul_hi !== 8'h00) begin n_fail++; $display("FAIL mulrst_out: got %h/%b %h want 00/0000 00", acc_bus, flags, mul_hi); end
      n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL mulrst_state: busy %b done %b want 0 0", busy, done); end
      saw_done = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (done !== 1'b0 || busy !== 1'b0) saw_done = 1'b1;
      end
      n_checks++; if (saw_done) begin n_fail++; $display("FAIL mulrst_no_done: got activity want none"); end
      load_b(8'h01);
      issue_op(8'h7F, ADD);
      n_checks++; if (done !== 1'b1 || acc_bus !== 8'h80 || flags !== 4'b0011) begin n_fail++; $display("FAIL mulrst_add: got %b %h/%b want 1 80/0011", done, acc_bus, flags); end
   endtask
`else
   task automatic test_mul_off;
      issue_op(8'h00, MUL);
      n_checks++; if (done !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL muloff_done: done %b busy %b want 1 0", done, busy); end
      n_checks++; if (acc_bus !== 8'h00 || flags !== 4'b1000 || mul_hi !== 8'h00) begin n_fail++; $display("FAIL muloff_zero: got %h/%b %h want 00/1000 00", acc_bus, flags, mul_hi); end
      load_b(8'h03);
      issue_op(8'h85, MUL);
      n_checks++; if (acc_bus !== 8'h85 || flags !== 4'b0010 || mul_hi !== 8'h00 || busy !== 1'b0) begin n_fail++; $display("FAIL muloff_pass: got %h/%b %h busy %b want 85/0010 00 0", acc_bus, flags, mul_hi, busy); end
      @(negedge clk);
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL muloff_pulse: got %b want 0", done); end
   endtask
`endif

   initial begin
      test_reset;
      test_add;
      test_sub;
      test_shift;
      test_logic;
      test_same_edge;
      test_back_to_back;
`ifdef ALU_MUL_EN
      test_mul;
      test_mul_reset;
`else
      test_mul_off;
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
